// File: rtl/alu_status_handler_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_status_handler_if
//  Description : ALU status bus between the retiring ALU / control unit side
//                (master) and the status/exception handler (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_status_handler_if #(
    parameter int CNT_W = 8
);
    // Retirement side
    logic             alu_valid;
    logic [3:0]       ALU_ctrl;
    logic [7:0]       ALU_status;
    logic [31:0]      pc;
    logic [1:0]       exc_mask;
    logic             clear_sticky;
    logic             exc_ack;

    // Handler side
    logic [7:0]       last_status;
    logic [7:0]       sticky_status;
    logic             exc_req;
    logic [3:0]       exc_cause;
    logic [31:0]      exc_epc;
    logic             stall;
    logic [CNT_W-1:0] exc_count;

    modport master (
        output alu_valid, ALU_ctrl, ALU_status, pc, exc_mask, clear_sticky, exc_ack,
        input  last_status, sticky_status, exc_req, exc_cause, exc_epc, stall, exc_count
    );

    modport slave (
        input  alu_valid, ALU_ctrl, ALU_status, pc, exc_mask, clear_sticky, exc_ack,
        output last_status, sticky_status, exc_req, exc_cause, exc_epc, stall, exc_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_status_handler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_status_handler
//  Description : Consumer end of the ALU status bus. Captures the status of
//                each retiring op, keeps sticky ovf/carry/div0/timeout flags,
//                and raises a MIPS-style exception request (cause + EPC) with
//                a req/ack handshake, stalling the pipe while it is open.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_status_handler #(
    parameter logic [3:0] OV_CAUSE    = 4'd12,
    parameter logic [3:0] DZ_CAUSE    = 4'd15,
    parameter int         ACK_TIMEOUT = 16,
    parameter int         CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_status_handler_if.slave bus
);

    localparam int                 c_TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_exc_req;
    logic               w_stall;

    logic               w_sample;
    logic               w_dz;
    logic               w_ov;
    logic               w_fault;
    logic               w_tmo_hit;
    logic [7:0]         w_sticky_set;

    logic [c_TMO_W-1:0] r_tmo;
    logic [7:0]         r_last_status;
    logic [7:0]         r_sticky;
    logic [3:0]         r_exc_cause;
    logic [31:0]        r_exc_epc;
    logic [CNT_W-1:0]   r_exc_count;

    // The op code and reserved status bits carry no information for this block.
    logic               w_unused_ok;
    assign w_unused_ok = &{1'b0, bus.ALU_ctrl, bus.ALU_status[1:0]};

    // Status is only taken while the pipe is not stalled.
    assign w_sample  = (r_state == c_ST_IDLE) && bus.alu_valid;
    assign w_dz      = w_sample && bus.ALU_status[2] && bus.exc_mask[1];
    assign w_ov      = w_sample && bus.ALU_status[6] && bus.exc_mask[0];
    assign w_fault   = w_dz || w_ov;
    // An ack arriving in the last allowed cycle still counts as an ack.
    assign w_tmo_hit = (r_state == c_ST_REQ) && !bus.exc_ack && (r_tmo == c_TMO_LAST);

    assign w_sticky_set = {1'b0,
                           w_sample && bus.ALU_status[6],
                           w_sample && bus.ALU_status[5],
                           2'b00,
                           w_sample && bus.ALU_status[2],
                           w_tmo_hit,
                           1'b0};

    // Exception handshake state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_exc_req   = 1'b0;
        w_stall     = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                w_stall = 1'b0;
                if (w_fault) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                w_exc_req = 1'b1;
                if (bus.exc_ack || w_tmo_hit) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Ack timeout counter: 1 in the first REQ cycle, counting while REQ persists.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (w_state_nxt == c_ST_REQ) begin
            r_tmo <= (r_state == c_ST_REQ) ? (r_tmo + c_TMO_ONE) : c_TMO_ONE;
        end else begin
            r_tmo <= '0;
        end
    end

    // Last-status capture and sticky flag accumulation (a set beats a clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_status <= 8'h00;
            r_sticky      <= 8'h00;
        end else begin
            if (w_sample) begin
                r_last_status <= {bus.ALU_status[7:2], 2'b00};
            end
            r_sticky <= (bus.clear_sticky ? 8'h00 : r_sticky) | w_sticky_set;
        end
    end

    // Cause/EPC latch and saturating exception counter, updated on each fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_cause <= 4'd0;
            r_exc_epc   <= 32'd0;
            r_exc_count <= '0;
        end else if (w_fault) begin
            r_exc_cause <= w_dz ? DZ_CAUSE : OV_CAUSE;
            r_exc_epc   <= bus.pc;
            if (r_exc_count != c_CNT_MAX) begin
                r_exc_count <= r_exc_count + c_CNT_ONE;
            end
        end
    end

    assign bus.last_status   = r_last_status;
    assign bus.sticky_status = r_sticky;
    assign bus.exc_req       = w_exc_req;
    assign bus.exc_cause     = r_exc_cause;
    assign bus.exc_epc       = r_exc_epc;
    assign bus.stall         = w_stall;
    assign bus.exc_count     = r_exc_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_status_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_status_handler
//  Description : Scoreboard bench for alu_status_handler. The driver issues
//                retiring ops and pushes the expected responses; a monitor
//                pops and compares whenever the DUT samples or raises/drops
//                an exception request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_status_handler;

    typedef struct {
        logic [3:0]  cause;
        logic [31:0] epc;
        logic [7:0]  cnt;
        int          dur;
        logic [7:0]  sticky;
    } exc_t;

    typedef struct {
        logic [7:0] last;
        logic [7:0] sticky;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_status_handler_if #(.CNT_W(8)) bus ();

    alu_status_handler #(
        .OV_CAUSE    (4'd12),
        .DZ_CAUSE    (4'd15),
        .ACK_TIMEOUT (16),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_fail = 0;

    exc_t excq[$];
    smp_t stq[$];

    logic [7:0] mdl_sticky = 8'h00;
    logic [7:0] mdl_cnt    = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT against the expected-response queues.
    exc_t cur;
    int   dur       = 0;
    logic in_req    = 1'b0;
    logic pend      = 1'b0;
    logic drain_chk = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pend      = 1'b0;
            in_req    = 1'b0;
            drain_chk = 1'b0;
            excq.delete();
            stq.delete();
        end else begin
            if (pend) begin
                if (stq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sample_queue: got empty expected entry (t=%0t)", $time);
                end else begin
                    smp_t s;
                    s = stq.pop_front();
                    chk("last_status", bus.last_status, s.last);
                    chk("sticky_after_sample", bus.sticky_status, s.sticky);
                end
            end
            if (drain_chk) begin
                chk("stall_after_drain", bus.stall, 1'b0);
                drain_chk = 1'b0;
            end
            if (bus.exc_req && !in_req) begin
                if (excq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_exc_req: got exc_req=1 expected 0 (t=%0t)", $time);
                end else begin
                    cur = excq.pop_front();
                    chk("exc_cause", bus.exc_cause, cur.cause);
                    chk("exc_epc", bus.exc_epc, cur.epc);
                    chk("exc_count", bus.exc_count, cur.cnt);
                    chk("stall_in_req", bus.stall, 1'b1);
                    in_req = 1'b1;
                    dur    = 1;
                end
            end else if (bus.exc_req && in_req) begin
                dur++;
            end else if (!bus.exc_req && in_req) begin
                in_req = 1'b0;
                chk("req_duration", dur, cur.dur);
                chk("cause_held", bus.exc_cause, cur.cause);
                chk("epc_held", bus.exc_epc, cur.epc);
                chk("sticky_after_req", bus.sticky_status, cur.sticky);
                chk("stall_in_drain", bus.stall, 1'b1);
                drain_chk = 1'b1;
            end
            pend = bus.alu_valid && !bus.stall;
        end
    end

    // Drive one retiring op for one cycle and record what must come back.
    task automatic issue_op(input logic [7:0] st, input logic [1:0] m, input logic clr,
                            input logic [3:0] ctrl, input logic [31:0] pcv,
                            input int ack_delay, output logic fault);
        exc_t e;
        smp_t s;
        fault    = (st[2] & m[1]) | (st[6] & m[0]);
        s.last   = {st[7:2], 2'b00};
        s.sticky = (clr ? 8'h00 : mdl_sticky) | (st & 8'h64);
        mdl_sticky = s.sticky;
        stq.push_back(s);
        if (fault) begin
            if (mdl_cnt != 8'hFF) mdl_cnt = mdl_cnt + 8'd1;
            e.cause = (st[2] & m[1]) ? 4'd15 : 4'd12;
            e.epc   = pcv;
            e.cnt   = mdl_cnt;
            e.dur   = (ack_delay >= 16) ? 16 : ack_delay + 1;
            if (ack_delay >= 16) mdl_sticky[1] = 1'b1;
            e.sticky = mdl_sticky;
            excq.push_back(e);
        end
        bus.alu_valid    = 1'b1;
        bus.ALU_status   = st;
        bus.exc_mask     = m;
        bus.clear_sticky = clr;
        bus.ALU_ctrl     = ctrl;
        bus.pc           = pcv;
        tick();
        bus.alu_valid    = 1'b0;
        bus.clear_sticky = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.stall && n < 40) begin
            tick();
            n++;
        end
        chk("stall_release", bus.stall, 1'b0);
    endtask

    // Handshake: hold ack off for ack_delay REQ cycles, optionally poking alu_valid.
    task automatic finish_exc(input int ack_delay, input logic poke);
        int n = 0;
        while (!bus.exc_req && n < 4) begin
            tick();
            n++;
        end
        chk("exc_req_seen", bus.exc_req, 1'b1);
        for (int i = 0; i < ack_delay; i++) begin
            if (poke && i == 0) begin
                bus.alu_valid  = 1'b1;
                bus.ALU_status = 8'(($urandom));
                bus.exc_mask   = 2'b11;
            end
            tick();
            bus.alu_valid = 1'b0;
        end
        bus.exc_ack = 1'b1;
        tick();
        bus.exc_ack = 1'b0;
        wait_idle();
    endtask

    task automatic run_op(input logic [7:0] st, input logic [1:0] m, input logic clr,
                          input logic [3:0] ctrl, input logic [31:0] pcv,
                          input int ack_delay, input logic poke);
        logic f;
        issue_op(st, m, clr, ctrl, pcv, ack_delay, f);
        if (f) finish_exc(ack_delay, poke);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic f;
        bus.alu_valid    = 1'b0;
        bus.ALU_ctrl     = 4'd0;
        bus.ALU_status   = 8'h00;
        bus.pc           = 32'd0;
        bus.exc_mask     = 2'b00;
        bus.clear_sticky = 1'b0;
        bus.exc_ack      = 1'b0;

        // Reset for two cycles: everything must read zero.
        rst = 1'b1;
        tick();
        tick();
        chk("rst_last_status", bus.last_status, 8'h00);
        chk("rst_sticky", bus.sticky_status, 8'h00);
        chk("rst_exc_req", bus.exc_req, 1'b0);
        chk("rst_exc_cause", bus.exc_cause, 4'd0);
        chk("rst_exc_epc", bus.exc_epc, 32'd0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_exc_count", bus.exc_count, 8'd0);
        rst = 1'b0;
        tick();

        // Masked sample, overflow exception, div0 priority, clear-with-set, timeout.
        run_op(8'h90, 2'b00, 1'b0, 4'd0, 32'h0000_0000, 0, 1'b0);
        tick();
        run_op(8'h40, 2'b01, 1'b0, 4'd2, 32'h0040_0010, 1, 1'b0);
        chk("count_after_first", bus.exc_count, 8'd1);
        run_op(8'h44, 2'b11, 1'b0, 4'b1001, 32'h0040_0020, 2, 1'b1);
        chk("sticky_div0_ovf", bus.sticky_status, 8'h44);
        run_op(8'h20, 2'b00, 1'b1, 4'd0, 32'h0040_0024, 0, 1'b0);
        tick();
        run_op(8'h40, 2'b01, 1'b0, 4'd3, 32'h0040_0030, 20, 1'b0);
        chk("sticky_timeout_bit", bus.sticky_status[1], 1'b1);
        run_op(8'h04, 2'b10, 1'b0, 4'b1001, 32'h0040_0034, 15, 1'b0);
        run_op(8'h04, 2'b10, 1'b0, 4'b1001, 32'h0040_0038, 16, 1'b0);

        // Reset during an open request drops it.
        issue_op(8'h40, 2'b01, 1'b0, 4'd1, 32'h0040_0100, 5, f);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_exc_req", bus.exc_req, 1'b0);
        chk("midrst_exc_count", bus.exc_count, 8'd0);
        chk("midrst_last_status", bus.last_status, 8'h00);
        chk("midrst_sticky", bus.sticky_status, 8'h00);
        chk("midrst_stall", bus.stall, 1'b0);
        chk("midrst_epc", bus.exc_epc, 32'd0);
        rst = 1'b0;
        mdl_sticky = 8'h00;
        mdl_cnt    = 8'h00;
        tick();

        // Randomized traffic.
        for (int i = 0; i < 120; i++) begin
            run_op(8'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
                   4'($urandom), $urandom, $urandom_range(0, 18), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        // Drive the exception counter into saturation.
        for (int i = 0; i < 270; i++) begin
            run_op(8'h40 | 8'($urandom_range(0, 255) & 8'hB8), 2'b01, 1'b0, 4'd0,
                   $urandom, 0, 1'b0);
        end
        chk("count_saturated", bus.exc_count, 8'hFF);

        tick();
        tick();
        chk("exc_queue_drained", excq.size(), 0);
        chk("sample_queue_drained", stq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
